// File: rtl/spc_reg_dump_pkg.sv
// Shared definitions for the special-register dump engine.
package spc_reg_dump_pkg;

    // Default geometry of the special register file
    localparam int NUM_REGS_DEF = 8;
    localparam int ADDR_W_DEF   = 3;
    localparam int DATA_W_DEF   = 32;

    // Special register indices; CPSR is the highest index so it always
    // comes out last in an ascending walk
    localparam int ZR   = 0;
    localparam int R1   = 1;
    localparam int R2   = 2;
    localparam int R3   = 3;
    localparam int SP   = 4;
    localparam int LR   = 5;
    localparam int PC   = 6;
    localparam int CPSR = 7;

    // Dump sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

endpackage

// File: rtl/spc_next_idx.sv
// Combinational search for the next set mask bit strictly above idx.
module spc_next_idx
    import spc_reg_dump_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic [NUM_REGS-1:0] mask,
    input  logic [ADDR_W-1:0]   idx,
    output logic [ADDR_W-1:0]   next_idx,
    output logic                none_left
);

    // Scan from the top down so the last hit is the lowest bit above idx
    always_comb begin
        next_idx  = '0;
        none_left = 1'b1;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(idx))) begin
                next_idx  = ADDR_W'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/spc_reg_dump.sv
// Walks the masked special registers in ascending order and streams each
// value out as a valid/ready beat, one FETCH and one SEND cycle per beat.
module spc_reg_dump
    import spc_reg_dump_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dump_req,
    input  logic [NUM_REGS-1:0] dump_mask,
    output logic [ADDR_W-1:0]   read_usr_addr,
    input  logic [DATA_W-1:0]   re_usr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    dump_state_t         state_q;
    dump_state_t         state_d;
    logic [NUM_REGS-1:0] mask_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [ADDR_W-1:0]   first_idx;
    logic [ADDR_W-1:0]   next_idx;
    logic                none_left;

    // Lowest set bit of the incoming mask picks the first register to read
    always_comb begin
        first_idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (dump_mask[i]) begin
                first_idx = ADDR_W'(i);
            end
        end
    end

    spc_next_idx #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_next_idx (
        .mask      (mask_q),
        .idx       (idx_q),
        .next_idx  (next_idx),
        .none_left (none_left)
    );

    // State register; reset wins over any request or handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and the state-derived outputs
    always_comb begin
        state_d       = state_q;
        out_valid     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        read_usr_addr = '0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (dump_req) begin
                    state_d = (|dump_mask) ? FETCH : DONE;
                end
            end
            FETCH: begin
                read_usr_addr = idx_q;
                state_d       = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = out_last ? DONE : FETCH;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Mask/index bookkeeping and the output beat holding registers;
    // the beat registers only load in FETCH so they stay frozen through SEND
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q   <= '0;
            idx_q    <= '0;
            out_data <= '0;
            out_addr <= '0;
            out_last <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dump_req && (|dump_mask)) begin
                        mask_q <= dump_mask;
                        idx_q  <= first_idx;
                    end
                end
                FETCH: begin
                    out_data <= re_usr;
                    out_addr <= idx_q;
                    out_last <= none_left;
                end
                SEND: begin
                    if (out_ready && !out_last) begin
                        idx_q <= next_idx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
